// File: rtl/crypt_dec_pkg.sv
// ----------------------------------------------------------------------------
// crypt_dec_pkg
// Shared definitions for the pipelined streaming decryption datapath.
//   DEF_*      : default configuration (bits per lane, lanes per word, rounds,
//                words per block), used as parameter defaults by the modules.
//   WORD_W     : word width of the default configuration.
//   KEY_W      : per-word key width of the default configuration.
//   stage_t    : one pipeline stage record {valid, data, key} (default widths).
//   rk_expand  : replicates a 2-bit round key across a wide vector; callers
//                size-cast the result down to their own lane width.
// ----------------------------------------------------------------------------
package crypt_dec_pkg;

    localparam int DEF_BYTE_W      = 8;
    localparam int DEF_LANES       = 4;
    localparam int DEF_STAGES      = 3;
    localparam int DEF_BLOCK_WORDS = 4;

    localparam int WORD_W   = DEF_LANES * DEF_BYTE_W;
    localparam int KEY_W    = 2 * DEF_STAGES;
    localparam int RK_MAX_W = 64;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
        logic [KEY_W-1:0]  key;
    } stage_t;

    // 2'b01 -> ...0101_0101; the low BYTE_W bits form the round byte.
    function automatic logic [RK_MAX_W-1:0] rk_expand(input logic [1:0] kb);
        return {(RK_MAX_W / 2){kb}};
    endfunction

endpackage

// File: rtl/crypt_dec_round.sv
// ----------------------------------------------------------------------------
// crypt_dec_round
// One registered inverse round. The round function sits in front of the
// stage register: out lane j = in lane ((j+1) mod LANES) XOR rk, where rk is
// this stage's 2 key bits replicated over a lane. The full key is registered
// alongside the data so each word keeps its own key down the pipe.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   adv                   advance enable (stage holds when low)
//   prev_valid/data/key   record from the previous stage (or the input)
//   valid_reg/data_reg/key_reg   this stage's registered record
// ----------------------------------------------------------------------------
module crypt_dec_round
    import crypt_dec_pkg::*;
#(
    parameter int BYTE_W    = DEF_BYTE_W,
    parameter int LANES     = DEF_LANES,
    parameter int STAGES    = DEF_STAGES,
    parameter int STAGE_IDX = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      adv,
    input  logic                      prev_valid,
    input  logic [LANES*BYTE_W-1:0]   prev_data,
    input  logic [2*STAGES-1:0]       prev_key,
    output logic                      valid_reg,
    output logic [LANES*BYTE_W-1:0]   data_reg,
    output logic [2*STAGES-1:0]       key_reg
);

    localparam int DW = LANES * BYTE_W;
    localparam int KW = 2 * STAGES;

    logic [1:0]        kb;
    logic [BYTE_W-1:0] rk;
    logic [DW-1:0]     data_next;

    // Highest key bits are consumed by the first stage.
    assign kb = prev_key[KW-1-2*STAGE_IDX -: 2];
    assign rk = BYTE_W'(rk_expand(kb));

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign data_next[gi*BYTE_W +: BYTE_W] =
                prev_data[((gi + 1) % LANES)*BYTE_W +: BYTE_W] ^ rk;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            key_reg   <= '0;
        end else if (adv) begin
            valid_reg <= prev_valid;
            data_reg  <= data_next;
            key_reg   <= prev_key;
        end
    end

endmodule

// File: rtl/pipelined_crypt_dec_stream.sv
// ----------------------------------------------------------------------------
// pipelined_crypt_dec_stream
// Fully pipelined streaming decryptor: one word per cycle enters STAGES
// inverse rounds (one register per round) and the decrypted words are packed
// into BLOCK_WORDS-word blocks handed out over a valid/ready handshake.
// Optional build macro: CRYPT_DEC_PERF_EN adds the blk_count port, a 16-bit
// wrapping count of consumed blocks.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   enable          global advance enable
//   in_valid/in_ready/in_data/in_key   input word handshake + per-word key
//   blk_valid/blk_ready/blk_data       assembled block handshake
//   blk_count       consumed-block counter (CRYPT_DEC_PERF_EN builds only)
// ----------------------------------------------------------------------------
module pipelined_crypt_dec_stream
    import crypt_dec_pkg::*;
#(
    parameter int BYTE_W      = DEF_BYTE_W,
    parameter int LANES       = DEF_LANES,
    parameter int STAGES      = DEF_STAGES,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [LANES*BYTE_W-1:0]               in_data,
    input  logic [2*STAGES-1:0]                   in_key,
    output logic                                  blk_valid,
    input  logic                                  blk_ready,
    output logic [BLOCK_WORDS*LANES*BYTE_W-1:0]   blk_data
`ifdef CRYPT_DEC_PERF_EN
    ,
    output logic [15:0]                           blk_count
`endif
);

    localparam int DW    = LANES * BYTE_W;
    localparam int KW    = 2 * STAGES;
    localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    logic                   adv;
    logic [STAGES:0]        chain_valid;
    logic [STAGES:0][DW-1:0] chain_data;
    logic [STAGES:0][KW-1:0] chain_key;
    logic [KW-1:0]          last_key_unused;

    logic [CNT_W-1:0]              cnt_reg;
    logic                          blk_valid_reg;
    logic [BLOCK_WORDS*DW-1:0]     blk_data_reg;

    // The whole pipe freezes while a finished block waits to be taken, so
    // nothing can overwrite it; a same-cycle take lets the pipe keep moving.
    assign adv      = enable && !(blk_valid_reg && !blk_ready);
    assign in_ready = adv;

    // Index 0 of the chain is the raw input; index s+1 is stage s's register.
    assign chain_valid[0] = in_valid;
    assign chain_data[0]  = in_data;
    assign chain_key[0]   = in_key;

    // The key has no consumer after the final round.
    assign last_key_unused = chain_key[STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            crypt_dec_round #(
                .BYTE_W    (BYTE_W),
                .LANES     (LANES),
                .STAGES    (STAGES),
                .STAGE_IDX (gi)
            ) u_round (
                .clk        (clk),
                .reset      (reset),
                .adv        (adv),
                .prev_valid (chain_valid[gi]),
                .prev_data  (chain_data[gi]),
                .prev_key   (chain_key[gi]),
                .valid_reg  (chain_valid[gi+1]),
                .data_reg   (chain_data[gi+1]),
                .key_reg    (chain_key[gi+1])
            );
        end
    endgenerate

    // Block assembler. Set beats clear: with a single-word block a take and a
    // new completion can coincide, and the new block must be presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            blk_valid_reg <= 1'b0;
            blk_data_reg  <= '0;
        end else begin
            if (blk_valid_reg && blk_ready) begin
                blk_valid_reg <= 1'b0;
            end
            if (adv && chain_valid[STAGES]) begin
                blk_data_reg[cnt_reg*DW +: DW] <= chain_data[STAGES];
                if (cnt_reg == CNT_W'(BLOCK_WORDS - 1)) begin
                    cnt_reg       <= '0;
                    blk_valid_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign blk_valid = blk_valid_reg;
    assign blk_data  = blk_data_reg;

`ifdef CRYPT_DEC_PERF_EN
    logic [15:0] blk_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_count_reg <= '0;
        end else if (blk_valid_reg && blk_ready) begin
            blk_count_reg <= blk_count_reg + 16'd1;
        end
    end

    assign blk_count = blk_count_reg;
`endif

endmodule

// File: tb/tb_pipelined_crypt_dec_stream.sv
// ----------------------------------------------------------------------------
// tb_pipelined_crypt_dec_stream
// Directed, table-driven bench for pipelined_crypt_dec_stream at default
// parameters (8-bit lanes, 4 lanes, 3 rounds, 4-word blocks). Expected words
// are hand-computed: three rotations give out[j] = in[(j+3)%4], XORed with
// the XOR of the three replicated round bytes.
// ----------------------------------------------------------------------------
module tb_pipelined_crypt_dec_stream;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [5:0]   in_key;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
`ifdef CRYPT_DEC_PERF_EN
    logic [15:0]  blk_count;
`endif

    always #5 clk = ~clk;

    pipelined_crypt_dec_stream dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data)
`ifdef CRYPT_DEC_PERF_EN
        ,
        .blk_count (blk_count)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [5:0]  key;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [127:0] exp_block(input int base);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = tbl[base + i].exp;
        return r;
    endfunction

    // Called at a negedge; leaves reset released at the following negedge.
    task automatic do_reset(input string name);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check({name, "_valid"}, 128'(blk_valid), 128'(0));
        check({name, "_data"}, blk_data, 128'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Four back-to-back words from tbl[base..base+3], consumer always ready.
    task automatic run_block(input int base, input string name);
        enable    = 1'b1;
        blk_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 4);
            if (c < 4) begin
                in_data = tbl[base + c].data;
                in_key  = tbl[base + c].key;
            end
            @(posedge clk);
            @(negedge clk);
            if (c == 6) begin
                check($sformatf("%s_valid_c%0d", name, c), 128'(blk_valid), 128'(1));
                for (int i = 0; i < 4; i++)
                    check($sformatf("%s_word%0d", name, i), 128'(blk_data[i*32 +: 32]),
                          128'(tbl[base + i].exp));
            end else begin
                check($sformatf("%s_valid_c%0d", name, c), 128'(blk_valid), 128'(0));
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int sent, got, stall, first_c, second_c;
        logic acc;
        logic [127:0] snap;

        reset     = 1'b1;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        blk_ready = 1'b0;

        tbl[0] = '{32'h04030201, 6'b00_00_01, 32'h56575451};
        tbl[1] = '{32'h00000000, 6'b00_00_00, 32'h00000000};
        tbl[2] = '{32'h44332211, 6'b11_11_11, 32'hCCDDEEBB};
        tbl[3] = '{32'hDEADBEEF, 6'b10_01_00, 32'h52411021};
        tbl[4] = '{32'h12345678, 6'b01_10_11, 32'h34567812};
        tbl[5] = '{32'hFFFFFFFF, 6'b00_00_10, 32'h55555555};
        tbl[6] = '{32'hA5A5A5A5, 6'b11_00_00, 32'h5A5A5A5A};
        tbl[7] = '{32'h0F0E0D0C, 6'b01_01_00, 32'h0E0D0C0F};

        // Power-on reset state.
        @(negedge clk);
        check("por_valid", 128'(blk_valid), 128'(0));
        check("por_data", blk_data, 128'(0));
        check("por_in_ready", 128'(in_ready), 128'(0));
        reset = 1'b0;

        // Single word: lands in slot 0 after edge N+3, not before.
        enable    = 1'b1;
        blk_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = tbl[0].data;
        in_key    = tbl[0].key;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("single_slot0_n2", 128'(blk_data[31:0]), 128'(0));
        @(negedge clk);
        check("single_slot0_n3", 128'(blk_data[31:0]), 128'(tbl[0].exp));
        check("single_valid", 128'(blk_valid), 128'(0));

        // Full block, table-driven.
        do_reset("rst_a");
        run_block(0, "blk0");

        // Backpressure: block 0 held 5 cycles while block 1 streams behind it.
        do_reset("rst_b");
        enable = 1'b1;
        sent = 0; got = 0; stall = 0; snap = '0;
        for (int c = 0; c < 80 && got < 2; c++) begin
            blk_ready = (got > 0) || (stall >= 5);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_data = tbl[sent].data;
                in_key  = tbl[sent].key;
            end
            #1;
            if (blk_valid && !blk_ready) begin
                if (stall == 0) snap = blk_data;
                else check($sformatf("bp_stable_%0d", stall), blk_data, snap);
                check($sformatf("bp_in_ready_%0d", stall), 128'(in_ready), 128'(0));
                stall++;
            end
            if (blk_valid && blk_ready) begin
                check($sformatf("bp_block%0d", got), blk_data, exp_block(4 * got));
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_blocks_seen", 128'(got), 128'(2));
        check("bp_stall_cycles", 128'(stall), 128'(5));

        // Enable toggling 1/0: latency doubles exactly.
        do_reset("rst_c");
        blk_ready = 1'b1;
        sent = 0; got = 0; first_c = -1; second_c = -1;
        for (int c = 0; c < 80 && got < 2; c++) begin
            enable   = (c % 2 == 0);
            in_valid = (sent < 8);
            if (sent < 8) begin
                in_data = tbl[sent].data;
                in_key  = tbl[sent].key;
            end
            #1;
            if (!enable && c < 6)
                check($sformatf("en_in_ready_c%0d", c), 128'(in_ready), 128'(0));
            if (blk_valid) begin
                check($sformatf("en_block%0d", got), blk_data, exp_block(4 * got));
                if (got == 0) first_c = c;
                else second_c = c;
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        check("en_first_cycle", 128'(first_c), 128'(13));
        check("en_second_cycle", 128'(second_c), 128'(21));
`ifdef CRYPT_DEC_PERF_EN
        check("perf_count_2", 128'(blk_count), 128'(2));
`endif

        // Reset after 2 of 4 words: partial block discarded, next block clean.
        do_reset("rst_d");
        enable    = 1'b1;
        blk_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_data  = tbl[c + 2].data;
            in_key   = tbl[c + 2].key;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_pre_slot0", 128'(blk_data[31:0]), 128'(tbl[2].exp));
        check("mid_pre_slot1", 128'(blk_data[63:32]), 128'(tbl[3].exp));
        do_reset("mid_rst");
        run_block(4, "mid_blk");

        // Three consumed blocks since the last reset for the counter.
        run_block(0, "blk_c1");
        run_block(4, "blk_c2");
`ifdef CRYPT_DEC_PERF_EN
        check("perf_count_3", 128'(blk_count), 128'(3));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_crypt_dec_stream.md
Name: pipelined_crypt_dec_stream

Overview:
Parametrised, fully pipelined streaming decryption datapath. Consumes one word of LANES bytes per cycle over a valid/ready handshake and applies STAGES key-driven inverse rounds, one register stage per round. It reassembles BLOCK_WORDS decrypted words into one output block, presented over a valid/ready handshake. It replaces fixed-FSM, one-block-at-a-time decryption with continuous throughput, per-word keys and backpressure.

Parameters:
BYTE_W, 8, bits per lane
LANES, 4, bytes per word
STAGES, 3, pipelined inverse rounds (>=1)
BLOCK_WORDS, 4, words per output block (>=1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
enable  input  1  global advance enable
in_valid  input  1  input word valid
in_ready  output  1  input word accepted when in_valid&&in_ready
in_data  input  LANES*BYTE_W  lane j at [j*BYTE_W +: BYTE_W]
in_key  input  2*STAGES  per-word key, 2 bits per stage
blk_valid  output  1  assembled block valid
blk_ready  input  1  block consumed when blk_valid&&blk_ready
blk_data  output  BLOCK_WORDS*LANES*BYTE_W  word i at [i*LANES*BYTE_W +: LANES*BYTE_W]
blk_count  output  16  completed-block counter (CRYPT_DEC_PERF_EN only)

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. All stage valids, stage data/key registers, the word slot counter, blk_valid, blk_data and blk_count clear to 0.
- Stage key bits: stage s (s=0 first) uses kb_s = in_key[2*STAGES-1-2s -: 2], so the highest key bits are consumed first. The round byte rk_s = kb_s replicated to BYTE_W bits (e.g. 2'b01 -> 8'h55).
- Round function f_s: out lane j = in lane ((j+1) mod LANES) XOR rk_s. This is purely combinational in front of stage register s.
- Key bits travel with the word through the pipeline, so every word is decrypted with its own key.
- Advance: adv = enable && !(blk_valid && !blk_ready). in_ready = adv. On adv, every stage shifts (valid included). Bubbles propagate as valid=0.
- Latency: a word accepted at edge N sits in stage s after edge N+s. It is written into block slot cnt at edge N+STAGES. Four back-to-back words accepted from edge N give blk_valid high after edge N+BLOCK_WORDS-1+STAGES (N+6 at defaults).
- Assembler: cnt runs 0..BLOCK_WORDS-1. A valid last-stage word on adv writes slot cnt and increments cnt. When the write lands in slot BLOCK_WORDS-1, cnt wraps to 0 and blk_valid is set on the same edge.
- blk_data holds stable while blk_valid=1 and blk_ready=0. The whole pipeline stalls in that state, and no word is lost or duplicated.
- Simultaneous blk_valid&&blk_ready with a last-stage word arriving: blk_valid clears, the new word writes slot 0, and throughput is unchanged.
- enable=0: stages and cnt freeze and in_ready=0. The output handshake still completes: blk_valid clears on blk_ready.
- Reset mid-block discards the partial block and all in-flight words.
- Partial blocks are never emitted.

Optional Feature:
CRYPT_DEC_PERF_EN defined: blk_count increments on each blk_valid&&blk_ready and wraps at 16'hFFFF->0. Not defined: the blk_count port and its counter are absent. Datapath behaviour is identical in both builds.

Decomposition:
- Package crypt_dec_pkg: localparam WORD_W=LANES*BYTE_W; function rk_expand(2-bit key -> BYTE_W); typedef of the stage record {valid, data, key}.
- One natural sub-module: crypt_dec_round, a single registered stage with its own f_s and stall input. The top generates STAGES instances in a generate loop and hosts the assembler.

Test Plan:
- Single word, key=6'b00_00_01, lanes {01,02,03,04}: net XOR is 8'h55 and the lane mapping is out[j]=in[(j+3)%4]. Slot 0 holds lanes {51,54,57,56} after edge N+3, and blk_valid stays 0.
- Four back-to-back words, blk_ready=1: blk_valid=1 after edge N+6 for one cycle, and blk_data matches the reference model word-for-word.
- blk_ready=0 held 5 cycles with a second block streaming: in_ready drops, blk_data is stable, and after release both blocks are delivered intact in order.
- enable toggled 1/0 every cycle over 8 words: two correct blocks are produced with latency stretched exactly by the disabled cycles.
- Reset asserted after 2 of 4 words of a block: all outputs are 0. The next 4 words form a clean block starting at slot 0.
- CRYPT_DEC_PERF_EN defined, 3 blocks consumed: blk_count=3. Preset near wrap: 16'hFFFF -> 0.
